// File: rtl/lvds_frame_align.sv
// ----------------------------------------------------------------------------
// lvds_frame_align
//
// Frame-alignment controller for one LTC2195 LVDS receive path. It watches
// the deserialized frame word and pulses bitslip at the ISERDES until the
// expected frame pattern appears consistently. After that it monitors the
// pattern while locked, and it starts alignment again if errors persist.
//
// Ports:
//   clk_in          - receiver clock (same domain as FR_out)
//   rst_in          - synchronous active-high reset
//   fr_in[15:0]     - deserialized frame word
//   fr_valid_in     - one-cycle strobe qualifying fr_in
//   relock_in       - one-cycle request to restart alignment
//   bitslip_out     - one-cycle bitslip pulse to the receiver
//   locked_out      - high while the frame pattern is aligned
//   align_fail_out  - high after MAX_SLIPS slips without lock
//   slip_count_out  - bitslips issued in the current alignment attempt
//   err_count_out   - saturating count of mismatches seen while locked
// ----------------------------------------------------------------------------
module lvds_frame_align #(
    parameter logic [15:0] EXPECTED       = 16'hFF00,
    parameter int          SETTLE_SAMPLES = 8,
    parameter int          LOCK_COUNT     = 64,
    parameter int          MAX_SLIPS      = 16,
    parameter int          ERR_THRESH     = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [15:0] fr_in,
    input  logic        fr_valid_in,
    input  logic        relock_in,
    output logic        bitslip_out,
    output logic        locked_out,
    output logic        align_fail_out,
    output logic [4:0]  slip_count_out,
    output logic [15:0] err_count_out
);

    localparam logic [2:0] ST_SETTLE = 3'd0;
    localparam logic [2:0] ST_CHECK  = 3'd1;
    localparam logic [2:0] ST_SLIP   = 3'd2;
    localparam logic [2:0] ST_LOCKED = 3'd3;
    localparam logic [2:0] ST_FAIL   = 3'd4;

    // Each counter only needs to reach (limit - 1). The transition fires
    // on the strobe that would otherwise take the counter to the limit.
    localparam int SET_W = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
    localparam int MAT_W = (LOCK_COUNT > 1)     ? $clog2(LOCK_COUNT)     : 1;
    localparam int CER_W = (ERR_THRESH > 1)     ? $clog2(ERR_THRESH)     : 1;

    localparam logic [SET_W-1:0] SET_LAST  = SET_W'(SETTLE_SAMPLES - 1);
    localparam logic [MAT_W-1:0] MAT_LAST  = MAT_W'(LOCK_COUNT - 1);
    localparam logic [CER_W-1:0] CER_LAST  = CER_W'(ERR_THRESH - 1);
    localparam logic [4:0]       SLIP_MAX  = 5'(MAX_SLIPS);

    logic [2:0]       state_q,      state_d;
    logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [MAT_W-1:0] match_cnt_q,  match_cnt_d;
    logic [CER_W-1:0] cons_err_q,   cons_err_d;
    logic [4:0]       slip_cnt_q,   slip_cnt_d;
    logic [15:0]      err_cnt_q,    err_cnt_d;
    logic             bitslip_q,    bitslip_d;
    logic             locked_q,     locked_d;
    logic             fail_q,       fail_d;

    logic             fr_match;

    assign fr_match = (fr_in == EXPECTED);

    // The next-state and next-output logic. Each output flop is loaded
    // together with the state it belongs to, so the outputs change in the
    // same cycle as the state. bitslip defaults low, which makes the SLIP
    // pulse exactly one cycle long.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        match_cnt_d  = match_cnt_q;
        cons_err_d   = cons_err_q;
        slip_cnt_d   = slip_cnt_q;
        err_cnt_d    = err_cnt_q;
        bitslip_d    = 1'b0;
        locked_d     = locked_q;
        fail_d       = fail_q;

        if (relock_in) begin
            // relock has priority over a coincident sample. The sample is dropped.
            state_d      = ST_SETTLE;
            settle_cnt_d = '0;
            match_cnt_d  = '0;
            cons_err_d   = '0;
            slip_cnt_d   = '0;
            locked_d     = 1'b0;
            fail_d       = 1'b0;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    if (fr_valid_in) begin
                        if (settle_cnt_q == SET_LAST) begin
                            state_d      = ST_CHECK;
                            settle_cnt_d = '0;
                            match_cnt_d  = '0;
                        end else begin
                            settle_cnt_d = settle_cnt_q + SET_W'(1);
                        end
                    end
                end

                ST_CHECK: begin
                    if (fr_valid_in) begin
                        if (fr_match) begin
                            if (match_cnt_q == MAT_LAST) begin
                                state_d     = ST_LOCKED;
                                locked_d    = 1'b1;
                                match_cnt_d = '0;
                                cons_err_d  = '0;
                            end else begin
                                match_cnt_d = match_cnt_q + MAT_W'(1);
                            end
                        end else begin
                            match_cnt_d = '0;
                            if (slip_cnt_q >= SLIP_MAX) begin
                                state_d = ST_FAIL;
                                fail_d  = 1'b1;
                            end else begin
                                state_d    = ST_SLIP;
                                bitslip_d  = 1'b1;
                                slip_cnt_d = slip_cnt_q + 5'd1;
                            end
                        end
                    end
                end

                ST_SLIP: begin
                    // The receiver output is unstable across the slip, so any
                    // strobe in this cycle is ignored.
                    state_d      = ST_SETTLE;
                    settle_cnt_d = '0;
                end

                ST_LOCKED: begin
                    if (fr_valid_in) begin
                        if (fr_match) begin
                            cons_err_d = '0;
                        end else begin
                            if (err_cnt_q != 16'hFFFF) begin
                                err_cnt_d = err_cnt_q + 16'd1;
                            end
                            if (cons_err_q == CER_LAST) begin
                                // Losing lock starts a new alignment attempt,
                                // so the slip budget is restored. err_count
                                // keeps its history.
                                state_d      = ST_SETTLE;
                                locked_d     = 1'b0;
                                slip_cnt_d   = '0;
                                cons_err_d   = '0;
                                settle_cnt_d = '0;
                            end else begin
                                cons_err_d = cons_err_q + CER_W'(1);
                            end
                        end
                    end
                end

                ST_FAIL: begin
                    // Stays here until relock_in, which is handled above.
                end

                default: begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = '0;
                end
            endcase
        end
    end

    // Registered state and outputs. The reset also clears a bitslip pulse
    // that is in flight.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= ST_SETTLE;
            settle_cnt_q <= '0;
            match_cnt_q  <= '0;
            cons_err_q   <= '0;
            slip_cnt_q   <= '0;
            err_cnt_q    <= '0;
            bitslip_q    <= 1'b0;
            locked_q     <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            match_cnt_q  <= match_cnt_d;
            cons_err_q   <= cons_err_d;
            slip_cnt_q   <= slip_cnt_d;
            err_cnt_q    <= err_cnt_d;
            bitslip_q    <= bitslip_d;
            locked_q     <= locked_d;
            fail_q       <= fail_d;
        end
    end

    assign bitslip_out    = bitslip_q;
    assign locked_out     = locked_q;
    assign align_fail_out = fail_q;
    assign slip_count_out = slip_cnt_q;
    assign err_count_out  = err_cnt_q;

endmodule

// File: tb/tb_lvds_frame_align.sv
// ----------------------------------------------------------------------------
// tb_lvds_frame_align
//
// Directed bench for lvds_frame_align. Instance u_dut uses the default
// parameters. A simple receiver model rotates the frame word left by one bit
// on every bitslip pulse. Instance u_sat uses a short settle time, a short
// lock time and a huge error threshold. This lets err_count reach its
// saturation point while the instance stays locked.
// ----------------------------------------------------------------------------
module tb_lvds_frame_align;

    localparam logic [15:0] EXP = 16'hFF00;

    logic        clk_in;
    logic        rst_in;

    logic [15:0] fr_a;
    logic        valid_a;
    logic        relock_a;
    logic        bitslip_a;
    logic        locked_a;
    logic        fail_a;
    logic [4:0]  slip_a;
    logic [15:0] err_a;

    logic [15:0] fr_b;
    logic        valid_b;
    logic        relock_b;
    logic        bitslip_b;
    logic        locked_b;
    logic        fail_b;
    logic [4:0]  slip_b;
    logic [15:0] err_b;

    int check_cnt;
    int fail_cnt;

    lvds_frame_align u_dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .fr_in          (fr_a),
        .fr_valid_in    (valid_a),
        .relock_in      (relock_a),
        .bitslip_out    (bitslip_a),
        .locked_out     (locked_a),
        .align_fail_out (fail_a),
        .slip_count_out (slip_a),
        .err_count_out  (err_a)
    );

    lvds_frame_align #(
        .EXPECTED       (16'hFF00),
        .SETTLE_SAMPLES (2),
        .LOCK_COUNT     (4),
        .MAX_SLIPS      (16),
        .ERR_THRESH     (65535)
    ) u_sat (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .fr_in          (fr_b),
        .fr_valid_in    (valid_b),
        .relock_in      (relock_b),
        .bitslip_out    (bitslip_b),
        .locked_out     (locked_b),
        .align_fail_out (fail_b),
        .slip_count_out (slip_b),
        .err_count_out  (err_b)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    function automatic logic [15:0] rotl1(input logic [15:0] w);
        return {w[14:0], w[15]};
    endfunction

    // Drive one cycle on the chosen instance and keep the other one idle.
    // The outputs are sampled 1 ns after the active edge.
    task automatic applyStimulus(input bit sel, input logic v, input logic [15:0] w,
                                 input logic rl);
        if (!sel) begin
            valid_a = v; fr_a = w; relock_a = rl;
            valid_b = 1'b0; relock_b = 1'b0;
        end else begin
            valid_b = v; fr_b = w; relock_b = rl;
            valid_a = 1'b0; relock_a = 1'b0;
        end
        @(posedge clk_in);
        #1;
        valid_a = 1'b0; relock_a = 1'b0;
        valid_b = 1'b0; relock_b = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("[TB] assertion %s", tag);
        end
    endtask

    // The directed sequence. The stages follow one another, and each stage
    // starts from the state the previous stage left behind.
    initial begin
        logic [15:0] word;
        int          pulses;
        logic        prev_bs;

        check_cnt = 0;
        fail_cnt  = 0;
        rst_in    = 1'b1;
        fr_a = '0; valid_a = 1'b0; relock_a = 1'b0;
        fr_b = '0; valid_b = 1'b0; relock_b = 1'b0;

        // Reset values.
        applyStimulus(0, 1'b0, 16'h0, 1'b0);
        applyStimulus(0, 1'b0, 16'h0, 1'b0);
        checkOutput("rst_bitslip", {31'd0, bitslip_a}, 32'd0);
        checkOutput("rst_locked",  {31'd0, locked_a},  32'd0);
        checkOutput("rst_fail",    {31'd0, fail_a},    32'd0);
        checkOutput("rst_slip",    {27'd0, slip_a},    32'd0);
        checkOutput("rst_err",     {16'd0, err_a},     32'd0);
        rst_in = 1'b0;

        // Lock after 3 slips. The receiver starts at EXPECTED rotated right
        // by 3 (16'h1FE0), so three left rotations reach the pattern.
        word = EXP;
        word = {word[2:0], word[15:3]};
        pulses  = 0;
        prev_bs = 1'b0;
        for (int i = 0; i < 500 && pulses < 3; i++) begin
            applyStimulus(0, 1'b1, word, 1'b0);
            if (bitslip_a) begin
                if (prev_bs) checkOutput("slip_back_to_back", 32'd1, 32'd0);
                pulses++;
                word = rotl1(word);
            end
            prev_bs = bitslip_a;
        end
        checkOutput("lock3_pulses", pulses, 32'd3);
        checkOutput("lock3_slipcnt", {27'd0, slip_a}, 32'd3);
        // One strobe is ignored in SLIP, 8 are settle samples and 64 are
        // compared. Lock therefore follows the 73rd strobe.
        for (int k = 1; k <= 73; k++) begin
            applyStimulus(0, 1'b1, word, 1'b0);
            if (k == 1)  checkOutput("slip_one_cycle", {31'd0, bitslip_a}, 32'd0);
            if (k == 72) checkOutput("lock3_not_yet", {31'd0, locked_a}, 32'd0);
            if (k == 73) checkOutput("lock3_locked",  {31'd0, locked_a}, 32'd1);
        end

        // Lock loss: 3 mismatches, 1 match, then 4 mismatches.
        for (int k = 1; k <= 3; k++) applyStimulus(0, 1'b1, 16'h0000, 1'b0);
        checkOutput("loss_err3",    {16'd0, err_a},    32'd3);
        checkOutput("loss_still",   {31'd0, locked_a}, 32'd1);
        applyStimulus(0, 1'b1, EXP, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, 1'b1, 16'h0000, 1'b0);
            if (k == 3) checkOutput("loss_hold3", {31'd0, locked_a}, 32'd1);
        end
        checkOutput("loss_unlocked", {31'd0, locked_a}, 32'd0);
        checkOutput("loss_err7",     {16'd0, err_a},    32'd7);
        checkOutput("loss_slip0",    {27'd0, slip_a},   32'd0);
        for (int k = 1; k <= 72; k++) begin
            applyStimulus(0, 1'b1, EXP, 1'b0);
            if (k == 71) checkOutput("relock_not_yet", {31'd0, locked_a}, 32'd0);
            if (k == 72) checkOutput("relock_locked",  {31'd0, locked_a}, 32'd1);
        end

        // Never-matching input. A relock request first leaves the locked state.
        applyStimulus(0, 1'b0, 16'h0000, 1'b1);
        checkOutput("nm_unlocked", {31'd0, locked_a}, 32'd0);
        checkOutput("nm_err_kept", {16'd0, err_a},    32'd7);
        pulses  = 0;
        prev_bs = 1'b0;
        for (int i = 0; i < 1000 && !fail_a; i++) begin
            applyStimulus(0, 1'b1, 16'h0000, 1'b0);
            if (bitslip_a) begin
                if (prev_bs) checkOutput("nm_back_to_back", 32'd1, 32'd0);
                pulses++;
            end
            prev_bs = bitslip_a;
        end
        checkOutput("nm_pulses",  pulses, 32'd16);
        checkOutput("nm_fail",    {31'd0, fail_a},   32'd1);
        checkOutput("nm_locked",  {31'd0, locked_a}, 32'd0);
        checkOutput("nm_slip16",  {27'd0, slip_a},   32'd16);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(0, 1'b1, 16'h0000, 1'b0);
            if (bitslip_a) pulses++;
        end
        checkOutput("nm_no_more", pulses, 32'd0);
        checkOutput("nm_fail_hold", {31'd0, fail_a}, 32'd1);
        applyStimulus(0, 1'b0, 16'h0000, 1'b1);
        checkOutput("nm_fail_clr", {31'd0, fail_a}, 32'd0);
        checkOutput("nm_slip_clr", {27'd0, slip_a}, 32'd0);
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(0, 1'b1, 16'h0000, 1'b0);
            if (k == 8) checkOutput("nm_settle8", {31'd0, bitslip_a}, 32'd0);
            if (k == 9) checkOutput("nm_resume",  {31'd0, bitslip_a}, 32'd1);
        end

        // Reset during SLIP. The previous step leaves the DUT in SLIP.
        rst_in = 1'b1;
        applyStimulus(0, 1'b1, 16'h0000, 1'b0);
        rst_in = 1'b0;
        checkOutput("rs_bitslip", {31'd0, bitslip_a}, 32'd0);
        checkOutput("rs_slip",    {27'd0, slip_a},    32'd0);
        checkOutput("rs_err",     {16'd0, err_a},     32'd0);
        checkOutput("rs_locked",  {31'd0, locked_a},  32'd0);
        checkOutput("rs_fail",    {31'd0, fail_a},    32'd0);
        pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(0, 1'b1, 16'h0000, 1'b0);
            if (bitslip_a) pulses++;
        end
        checkOutput("rs_no_early", pulses, 32'd0);
        applyStimulus(0, 1'b1, 16'h0000, 1'b0);
        checkOutput("rs_first_cmp", {31'd0, bitslip_a}, 32'd1);

        // relock coinciding with a mismatch strobe in CHECK. One strobe is
        // ignored in SLIP and 8 settle samples follow, which leads to CHECK.
        for (int k = 1; k <= 9; k++) applyStimulus(0, 1'b1, 16'h0000, 1'b0);
        checkOutput("rl_pre_slip", {27'd0, slip_a}, 32'd1);
        applyStimulus(0, 1'b1, 16'h0000, 1'b1);
        checkOutput("rl_no_slip", {31'd0, bitslip_a}, 32'd0);
        checkOutput("rl_slip0",   {27'd0, slip_a},    32'd0);
        pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(0, 1'b1, 16'h0000, 1'b0);
            if (bitslip_a) pulses++;
        end
        checkOutput("rl_settle", pulses, 32'd0);
        applyStimulus(0, 1'b1, 16'h0000, 1'b0);
        checkOutput("rl_then_slip", {31'd0, bitslip_a}, 32'd1);

        // Saturation on u_sat: lock after 2 settle + 4 match strobes, then
        // drive more than 65535 mismatches. One match part-way through keeps
        // the consecutive-error count below the threshold.
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1, 1'b1, EXP, 1'b0);
            if (k == 5) checkOutput("sat_not_yet", {31'd0, locked_b}, 32'd0);
        end
        checkOutput("sat_locked", {31'd0, locked_b}, 32'd1);
        for (int k = 0; k < 40000; k++) applyStimulus(1, 1'b1, 16'h1234, 1'b0);
        checkOutput("sat_err40000", {16'd0, err_b}, 32'd40000);
        applyStimulus(1, 1'b1, EXP, 1'b0);
        for (int k = 0; k < 25534; k++) applyStimulus(1, 1'b1, 16'h1234, 1'b0);
        checkOutput("sat_err65534", {16'd0, err_b}, 32'd65534);
        applyStimulus(1, 1'b1, 16'h1234, 1'b0);
        checkOutput("sat_errmax", {16'd0, err_b}, 32'd65535);
        for (int k = 0; k < 5; k++) applyStimulus(1, 1'b1, 16'h1234, 1'b0);
        checkOutput("sat_hold",       {16'd0, err_b},    32'd65535);
        checkOutput("sat_still_lock", {31'd0, locked_b}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", check_cnt, fail_cnt);
        $finish;
    end

endmodule
